// File: rtl/sched_pkg.sv
// Shared types and constants for the issue scoreboard: register specifier
// width, register count and the in-flight write limit.
package sched_pkg;

  localparam int IDW          = 5;
  localparam int NREGS        = 32;
  localparam int MAX_INFLIGHT = 4;
  localparam int CNTW         = 3;

  typedef logic [IDW-1:0] reg_id_t;

  localparam reg_id_t ZERO_REG  = 5'd0;
  localparam reg_id_t FLAGS_REG = 5'd13;

endpackage : sched_pkg

// File: rtl/issue_scoreboard_busy_table.sv
// Per-register busy bits with one set port, one clear port, a flush and three
// combinational lookups (rd0/rd1/wr). Register 0 never reports busy.
module busy_table
  import sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             set_en,
  input  logic [IDW-1:0]   set_id,
  input  logic             clr_en,
  input  logic [IDW-1:0]   clr_id,
  input  logic [IDW-1:0]   rd0_id,
  input  logic [IDW-1:0]   rd1_id,
  input  logic [IDW-1:0]   wr_id,
  output logic             rd0_busy,
  output logic             rd1_busy,
  output logic             wr_busy,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_q, busy_d;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_en) busy_d[clr_id] = 1'b0;
      // Set is applied after clear so a same-cycle set/clear leaves the new owner busy.
      if (set_en) busy_d[set_id] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign rd0_busy = (rd0_id != ZERO_REG) & busy_q[rd0_id];
  assign rd1_busy = (rd1_id != ZERO_REG) & busy_q[rd1_id];
  assign wr_busy  = (wr_id  != ZERO_REG) & busy_q[wr_id];
  assign busy_vec = busy_q;

endmodule : busy_table

// File: rtl/issue_scoreboard.sv
// Issue-stage RAW/WAW hazard controller with in-flight write limit and a
// registered issue bus. Define ISSUE_WB_FORWARD_EN to let a same-cycle writeback clear hazards.
module issue_scoreboard
  import sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [IDW-1:0]   dec_rd0,
  input  logic [IDW-1:0]   dec_rd1,
  input  logic [IDW-1:0]   dec_wr,
  input  logic             wb_valid,
  input  logic [IDW-1:0]   wb_id,
  input  logic             flush,
  output logic             issue_valid,
  output logic [IDW-1:0]   issue_rd0,
  output logic [IDW-1:0]   issue_rd1,
  output logic [IDW-1:0]   issue_wr,
  output logic [NREGS-1:0] busy_vec,
  output logic [CNTW-1:0]  inflight,
  output logic             err_wb
);

  logic            rd0_busy, rd1_busy, wr_busy;
  logic            hazard, full, accept;
  logic            set_en, clr_en, spurious_wb;
  logic [CNTW-1:0] inflight_q, inflight_d;
  logic            err_q;
  logic            issue_valid_q;
  reg_id_t         issue_rd0_q, issue_rd1_q, issue_wr_q;

  assign clr_en      = wb_valid & (wb_id != ZERO_REG) &  busy_vec[wb_id];
  assign spurious_wb = wb_valid & (wb_id != ZERO_REG) & ~busy_vec[wb_id];

`ifdef ISSUE_WB_FORWARD_EN
  // A register completing writeback this cycle no longer blocks its consumers.
  assign hazard = (rd0_busy & ~(clr_en & (wb_id == dec_rd0)))
                | (rd1_busy & ~(clr_en & (wb_id == dec_rd1)))
                | (wr_busy  & ~(clr_en & (wb_id == dec_wr)));
  assign full   = (dec_wr != ZERO_REG) & (inflight_q == CNTW'(MAX_INFLIGHT)) & ~clr_en;
`else
  assign hazard = rd0_busy | rd1_busy | wr_busy;
  assign full   = (dec_wr != ZERO_REG) & (inflight_q == CNTW'(MAX_INFLIGHT));
`endif

  assign dec_ready = ~hazard & ~full & ~flush;
  assign accept    = dec_valid & dec_ready;
  assign set_en    = accept & (dec_wr != ZERO_REG);

  busy_table u_busy_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .set_en   (set_en),
    .set_id   (dec_wr),
    .clr_en   (clr_en),
    .clr_id   (wb_id),
    .rd0_id   (dec_rd0),
    .rd1_id   (dec_rd1),
    .wr_id    (dec_wr),
    .rd0_busy (rd0_busy),
    .rd1_busy (rd1_busy),
    .wr_busy  (wr_busy),
    .busy_vec (busy_vec)
  );

  always_comb begin
    inflight_d = inflight_q;
    if (flush) begin
      inflight_d = '0;
    end else begin
      case ({set_en, clr_en})
        2'b10:   inflight_d = inflight_q + CNTW'(1);
        2'b01:   inflight_d = inflight_q - CNTW'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q    <= '0;
      err_q         <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_rd0_q   <= ZERO_REG;
      issue_rd1_q   <= ZERO_REG;
      issue_wr_q    <= ZERO_REG;
    end else begin
      inflight_q <= inflight_d;
      // err_wb survives flush; a writeback squashed by flush cannot raise it.
      err_q      <= err_q | (spurious_wb & ~flush);
      if (flush) begin
        issue_valid_q <= 1'b0;
        issue_rd0_q   <= ZERO_REG;
        issue_rd1_q   <= ZERO_REG;
        issue_wr_q    <= ZERO_REG;
      end else begin
        issue_valid_q <= accept;
        if (accept) begin
          issue_rd0_q <= dec_rd0;
          issue_rd1_q <= dec_rd1;
          issue_wr_q  <= dec_wr;
        end
      end
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_rd0   = issue_rd0_q;
  assign issue_rd1   = issue_rd1_q;
  assign issue_wr    = issue_wr_q;
  assign inflight    = inflight_q;
  assign err_wb      = err_q;

endmodule : issue_scoreboard

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: expected issue transactions are queued
// when an accept is expected and compared when issue_valid appears.
module tb_issue_scoreboard;

  typedef struct packed {
    logic [4:0] rd0;
    logic [4:0] rd1;
    logic [4:0] wr;
  } issue_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid = 1'b0;
  logic        dec_ready;
  logic [4:0]  dec_rd0 = '0, dec_rd1 = '0, dec_wr = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_id = '0;
  logic        flush = 1'b0;
  logic        issue_valid;
  logic [4:0]  issue_rd0, issue_rd1, issue_wr;
  logic [31:0] busy_vec;
  logic [2:0]  inflight;
  logic        err_wb;

  int     vectors = 0;
  int     miscompares = 0;
  issue_t exp_q[$];

`ifdef ISSUE_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  issue_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_rd0     (dec_rd0),
    .dec_rd1     (dec_rd1),
    .dec_wr      (dec_wr),
    .wb_valid    (wb_valid),
    .wb_id       (wb_id),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_rd0   (issue_rd0),
    .issue_rd1   (issue_rd1),
    .issue_wr    (issue_wr),
    .busy_vec    (busy_vec),
    .inflight    (inflight),
    .err_wb      (err_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called 1ns after a rising edge: drives one cycle of inputs, checks the
  // combinational ready, then checks the issue bus after the next edge.
  task automatic cycle(input string tag, input logic v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] w, input logic wbv, input logic [4:0] wbid,
                       input logic fl, input logic exp_ready);
    issue_t got;
    issue_t want;
    logic   pending;
    dec_valid = v; dec_rd0 = r0; dec_rd1 = r1; dec_wr = w;
    wb_valid = wbv; wb_id = wbid; flush = fl;
    #1;
    check({tag, ".dec_ready"}, 32'(dec_ready), 32'(exp_ready));
    pending = v & exp_ready;
    if (pending) exp_q.push_back('{rd0: r0, rd1: r1, wr: w});
    @(posedge clk);
    #1;
    dec_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    check({tag, ".issue_valid"}, 32'(issue_valid), 32'(pending));
    if (issue_valid === 1'b1 && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = '{rd0: issue_rd0, rd1: issue_rd1, wr: issue_wr};
      check({tag, ".issue_fields"}, 32'(got), 32'(want));
    end
  endtask

  initial begin
    #12;
    check("reset.issue_valid", 32'(issue_valid), 32'd0);
    check("reset.busy_vec", busy_vec, 32'd0);
    check("reset.inflight", 32'(inflight), 32'd0);
    check("reset.err_wb", 32'(err_wb), 32'd0);
    check("reset.issue_wr", 32'(issue_wr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic issue: rd0=1 rd1=2 wr=3.
    cycle("basic", 1, 5'd1, 5'd2, 5'd3, 0, 5'd0, 0, 1);
    check("basic.busy_vec", busy_vec, 32'h0000_0008);
    check("basic.inflight", 32'(inflight), 32'd1);

    // RAW on r3 stalls until writeback.
    cycle("raw_stall0", 1, 5'd3, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    cycle("raw_stall1", 1, 5'd0, 5'd3, 5'd0, 0, 5'd0, 0, 0);
    cycle("raw_wb", 1, 5'd3, 5'd0, 5'd0, 1, 5'd3, 0, FWD);
`ifndef ISSUE_WB_FORWARD_EN
    cycle("raw_after_wb", 1, 5'd3, 5'd0, 5'd0, 0, 5'd0, 0, 1);
`endif
    check("raw.busy_vec", busy_vec, 32'd0);
    check("raw.inflight", 32'(inflight), 32'd0);

    // Fill to MAX_INFLIGHT, including the flags register among the readers.
    cycle("fill4", 1, 5'd13, 5'd0, 5'd4, 0, 5'd0, 0, 1);
    cycle("fill5", 1, 5'd0, 5'd0, 5'd5, 0, 5'd0, 0, 1);
    cycle("fill6", 1, 5'd0, 5'd0, 5'd6, 0, 5'd0, 0, 1);
    cycle("fill7", 1, 5'd0, 5'd0, 5'd7, 0, 5'd0, 0, 1);
    check("full.inflight", 32'(inflight), 32'd4);
    check("full.busy_vec", busy_vec, 32'h0000_00F0);
    cycle("full_stall", 1, 5'd0, 5'd0, 5'd8, 0, 5'd0, 0, 0);
    cycle("store_wr0", 1, 5'd1, 5'd2, 5'd0, 0, 5'd0, 0, 1);
    cycle("waw_stall", 1, 5'd0, 5'd0, 5'd5, 0, 5'd0, 0, 0);
    cycle("full_wb4", 1, 5'd0, 5'd0, 5'd8, 1, 5'd4, 0, FWD);
`ifndef ISSUE_WB_FORWARD_EN
    check("full_wb4.inflight", 32'(inflight), 32'd3);
    cycle("full_after_wb", 1, 5'd0, 5'd0, 5'd8, 0, 5'd0, 0, 1);
`endif
    check("refill.inflight", 32'(inflight), 32'd4);
    check("refill.busy_vec", busy_vec, 32'h0000_01E0);

    // Spurious writeback to an idle register.
    cycle("spurious", 0, 5'd0, 5'd0, 5'd0, 1, 5'd9, 0, 1);
    check("spurious.err_wb", 32'(err_wb), 32'd1);
    check("spurious.busy_vec", busy_vec, 32'h0000_01E0);
    check("spurious.inflight", 32'(inflight), 32'd4);
    cycle("wb_zero", 0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 0, 1);
    check("sticky.err_wb", 32'(err_wb), 32'd1);
    check("wb_zero.inflight", 32'(inflight), 32'd4);

    // Retire r8 to leave three in flight, then flush alongside a would-be accept.
    cycle("wb8", 0, 5'd0, 5'd0, 5'd0, 1, 5'd8, 0, 1);
    check("wb8.inflight", 32'(inflight), 32'd3);
    cycle("flush", 1, 5'd1, 5'd2, 5'd10, 1, 5'd5, 1, 0);
    check("flush.busy_vec", busy_vec, 32'd0);
    check("flush.inflight", 32'(inflight), 32'd0);
    check("flush.err_wb", 32'(err_wb), 32'd1);
    check("flush.issue_wr", 32'(issue_wr), 32'd0);

    // Asynchronous reset while stalled with an issue on the bus.
    cycle("pre_rst", 1, 5'd0, 5'd0, 5'd3, 0, 5'd0, 0, 1);
    dec_valid = 1'b1; dec_rd0 = 5'd3; dec_rd1 = 5'd0; dec_wr = 5'd0;
    #1;
    check("pre_rst.dec_ready", 32'(dec_ready), 32'd0);
    check("pre_rst.issue_valid", 32'(issue_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst.issue_valid", 32'(issue_valid), 32'd0);
    check("async_rst.busy_vec", busy_vec, 32'd0);
    check("async_rst.inflight", 32'(inflight), 32'd0);
    check("async_rst.err_wb", 32'(err_wb), 32'd0);
    check("async_rst.issue_wr", 32'(issue_wr), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_issue_scoreboard
